capture_dump_ctrl: RTL and testbench
====================================

CAPTURE_DUMP_CTRL -- requirements
Module: capture_dump_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, buffer depth in bytes (power of two, 4..32768).
REQ-002 The block SHALL have parameter ADDR_W, default 10, equal to log2(DEPTH).
REQ-003 The block SHALL have port sys_clk  in  1  single clock; all logic rising-edge.
REQ-004 The block SHALL have port sys_rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port trigger_save_data  in  1  one-cycle pulse; request a new capture.
REQ-006 The block SHALL have port trigger_output_data  in  1  one-cycle pulse; request a dump.
REQ-007 The block SHALL have port in_valid  in  1  capture byte strobe.
REQ-008 The block SHALL have port in_data  in  8  captured byte.
REQ-009 The block SHALL have port out_valid  out  1  dump byte valid.
REQ-010 The block SHALL have port out_data  out  8  dump byte.
REQ-011 The block SHALL have port out_ready  in  1  downstream accept.
REQ-012 The block SHALL have port state_led  out  2  state code: 0 IDLE, 1 CAPTURE, 2 DONE, 3 DUMP.
REQ-013 The block SHALL have port capture_count  out  ADDR_W+1  bytes held in buffer.

Function
REQ-014 The block SHALL hold a DEPTH x 8 buffer with synchronous one-cycle read.
REQ-015 IDLE: trigger_save_data -> CAPTURE with count cleared; trigger_output_data ignored.
REQ-016 CAPTURE: each in_valid cycle writes in_data at address count and increments count by 1.
REQ-017 CAPTURE: a write taking count to DEPTH -> DONE in the next cycle; later in_valid bytes are dropped.
REQ-018 CAPTURE: trigger_output_data ends capture -> DUMP (an in_valid byte in the same cycle is still stored); trigger_save_data ignored.
REQ-019 DONE: trigger_save_data -> CAPTURE with count cleared; trigger_output_data -> DUMP if count>0, else stays DONE.
REQ-020 Both triggers in the same cycle in DONE: save SHALL take priority.
REQ-021 DUMP: bytes SHALL be emitted in address order 0..count-1; first out_valid asserted in cycle T+2, where T is the DUMP-entry trigger cycle.
REQ-022 out_valid/out_data SHALL be registered and held stable until the cycle out_ready=1; a transfer occurs when out_valid and out_ready are both 1.
REQ-023 Back-to-back transfers SHALL be sustained at one byte per cycle while out_ready=1.
REQ-024 After the last byte transfers, out_valid SHALL deassert in the next cycle -> DONE, with buffer and count retained so that a repeat dump is possible.
REQ-025 DUMP: both triggers SHALL be ignored.
REQ-026 in_valid outside CAPTURE SHALL be ignored.
REQ-027 state_led SHALL reflect the current state registered, with no combinational path from inputs.

Reset
REQ-028 On sys_rst=1: state IDLE, state_led=0, capture_count=0, out_valid=0, out_data=0, read/write pointers 0; buffer contents need not be cleared.
REQ-029 Reset asserted mid-CAPTURE or mid-DUMP SHALL abort immediately, with no further writes or out_valid after assertion.
REQ-030 After deassertion, the first trigger SHALL be accepted no later than the second sys_clk edge.

Configuration
REQ-031 Macro CAPTURE_LENGTH_HEADER_EN: when defined, DUMP SHALL first emit 2 header bytes {count[15:8], count[7:0]} (count zero-extended to 16 bits) under the same handshake, then the data; first header byte at T+2.
REQ-032 Without CAPTURE_LENGTH_HEADER_EN, DUMP SHALL emit data bytes only, and the header logic SHALL be absent.

Verification (DEPTH=16, header disabled unless stated)
REQ-033 Reset, save pulse, 5 in_valid bytes 0x10..0x14, output pulse -> state 1 then 3; out bytes 0x10..0x14 with out_ready=1 held; back to state 2, count=5.
REQ-034 Save, 20 in_valid bytes 0x00..0x13 -> state 2 after 16th byte, count=16; dump yields 0x00..0x0F only.
REQ-035 Dump with out_ready toggling 1,0,0,1 each byte -> each out_data held stable while stalled, no byte lost or duplicated, 16 bytes total.
REQ-036 In DONE with count=3, save and output pulsed in the same cycle -> state 1, count=0, no out_valid.
REQ-037 sys_rst asserted on 2nd dump byte -> out_valid=0 immediately, state_led=0, count=0.
REQ-038 CAPTURE_LENGTH_HEADER_EN defined, 3 bytes 0xAA,0xBB,0xCC captured -> dump 0x00,0x03,0xAA,0xBB,0xCC.

Source files
------------

// File: rtl/capture_dump_ctrl.sv
// Byte capture buffer: records an in_valid stream, then replays it over a valid/ready port.
// Optional macro CAPTURE_LENGTH_HEADER_EN prefixes each dump with a 16-bit byte count.
module capture_dump_ctrl #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              trigger_save_data,
   input  logic              trigger_output_data,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic [1:0]        state_led,
   output logic [ADDR_W:0]   capture_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2,
      DUMP    = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   state_t            state_reg, state_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              wr_en;
   logic [7:0]        buf_mem [DEPTH];
   logic [ADDR_W+1:0] idx_reg;
   logic [ADDR_W+1:0] total;
   logic              more;
   logic              slot_free;
   logic [7:0]        byte_next;
   logic              out_valid_reg;
   logic [7:0]        out_data_reg;

`ifdef CAPTURE_LENGTH_HEADER_EN
   logic [15:0]       count16;
   logic [ADDR_W-1:0] data_addr;

   assign count16   = 16'(count_reg);
   assign data_addr = idx_reg[ADDR_W-1:0] - ADDR_W'(2);
   assign total     = {1'b0, count_reg} + (ADDR_W+2)'(2);

   always_comb begin
      if (idx_reg == '0)
         byte_next = count16[15:8];
      else if (idx_reg == (ADDR_W+2)'(1))
         byte_next = count16[7:0];
      else
         byte_next = buf_mem[data_addr];
   end
`else
   assign total     = {1'b0, count_reg};
   assign byte_next = buf_mem[idx_reg[ADDR_W-1:0]];
`endif

   assign more      = idx_reg < total;
   assign slot_free = !out_valid_reg || out_ready;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      wr_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger_save_data) begin
               state_next = CAPTURE;
               count_next = '0;
            end
         end
         CAPTURE: begin
            if (in_valid && count_reg != FULL) begin
               wr_en      = 1'b1;
               count_next = count_reg + 1'b1;
            end
            // An empty capture has nothing to replay, so it parks in DONE instead of DUMP.
            if (trigger_output_data)
               state_next = (count_next != '0) ? DUMP : DONE;
            else if (count_next == FULL)
               state_next = DONE;
         end
         DONE: begin
            if (trigger_save_data) begin
               state_next = CAPTURE;
               count_next = '0;
            end else if (trigger_output_data && count_reg != '0) begin
               state_next = DUMP;
            end
         end
         DUMP: begin
            if (!more && slot_free)
               state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en)
         buf_mem[count_reg[ADDR_W-1:0]] <= in_data;
   end

   // Output register reloads whenever its slot is free, giving one byte per cycle under ready.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         idx_reg       <= '0;
      end else if (state_reg != DUMP) begin
         out_valid_reg <= 1'b0;
         idx_reg       <= '0;
      end else if (slot_free) begin
         if (more) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= byte_next;
            idx_reg       <= idx_reg + 1'b1;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_data      = out_data_reg;
   assign state_led     = state_reg;
   assign capture_count = count_reg;

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Self-checking bench for capture_dump_ctrl (DEPTH=16): vector table for the capture path,
// hand-written sequences for dump, stall, trigger priority and reset abort; scoreboard on out bytes.
module tb_capture_dump_ctrl;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              trigger_save_data = 1'b0;
   logic              trigger_output_data = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready = 1'b0;
   logic [1:0]        state_led;
   logic [ADDR_W:0]   capture_count;

   always #5 sys_clk = ~sys_clk;

   capture_dump_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .sys_clk             (sys_clk),
      .sys_rst             (sys_rst),
      .trigger_save_data   (trigger_save_data),
      .trigger_output_data (trigger_output_data),
      .in_valid            (in_valid),
      .in_data             (in_data),
      .out_valid           (out_valid),
      .out_data            (out_data),
      .out_ready           (out_ready),
      .state_led           (state_led),
      .capture_count       (capture_count)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic       held_valid = 1'b0;
   logic [7:0] held_data  = 8'h00;
   logic [3:0] ready_pat  = 4'b1001;

   typedef struct {
      logic       s;
      logic       o;
      logic       v;
      logic [7:0] d;
      logic [1:0] st;
      logic [4:0] cnt;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end else begin
         $display("[TB] ok %s = 0x%0h", name, actual);
      end
   endtask

   // Transfers are decided at the next rising edge; inputs are stable at the falling edge.
   always @(negedge sys_clk) begin
      if (held_valid) begin
         check("stall_hold_valid", out_valid, 1);
         check("stall_hold_data", out_data, held_data);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0)
            check("unexpected_byte_queue", exp_q.size(), 1);
         else
            check("dump_byte", out_data, exp_q.pop_front());
      end
      held_valid = (out_valid === 1'b1) && (out_ready === 1'b0) && !sys_rst;
      held_data  = out_data;
   end

   task automatic step(input logic s, input logic o, input logic v, input logic [7:0] d);
      trigger_save_data   = s;
      trigger_output_data = o;
      in_valid            = v;
      in_data             = d;
      @(posedge sys_clk);
      #1;
      trigger_save_data   = 1'b0;
      trigger_output_data = 1'b0;
      in_valid            = 1'b0;
   endtask

   task automatic push_hdr(input int n);
`ifdef CAPTURE_LENGTH_HEADER_EN
      exp_q.push_back(8'((n >> 8) & 255));
      exp_q.push_back(8'(n & 255));
`else
      if (n < 0) exp_q.push_back(8'h00);
`endif
   endtask

   task automatic wait_done(input string name, input logic toggle);
      int k = 0;
      while (state_led !== 2'd2 && k < 400) begin
         out_ready = toggle ? ready_pat[k % 4] : 1'b1;
         @(posedge sys_clk);
         #1;
         k++;
      end
      out_ready = 1'b1;
      check({name, "_finished_in_budget"}, (k < 400) ? 1 : 0, 1);
      check({name, "_all_bytes_seen"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 5'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h55, 2'd0, 5'd0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 5'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h10, 2'd1, 5'd1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 5'd2};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h12, 2'd1, 5'd3};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h13, 2'd1, 5'd4};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h14, 2'd1, 5'd5};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 5'd5};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 5'd5};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd3, 5'd5};

      // Reset state
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_state", state_led, 0);
      check("rst_count", capture_count, 0);
      sys_rst = 1'b0;
      out_ready = 1'b1;

      // Capture five bytes, then dump them
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].o && tbl[i].st == 2'd3) begin
            push_hdr(5);
            for (int b = 0; b < 5; b++) exp_q.push_back(8'h10 + 8'(b));
         end
         step(tbl[i].s, tbl[i].o, tbl[i].v, tbl[i].d);
         check($sformatf("row%0d_state", i), state_led, tbl[i].st);
         check($sformatf("row%0d_count", i), capture_count, tbl[i].cnt);
      end
      check("dump_t1_no_valid", out_valid, 0);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("dump_t2_valid", out_valid, 1);
      wait_done("dump5", 1'b0);
      check("dump5_state", state_led, 2);
      check("dump5_count", capture_count, 5);
      check("dump5_valid_low", out_valid, 0);

      // Overflow: 20 bytes offered, 16 kept; dump under a stalling sink
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("save_from_done_state", state_led, 1);
      check("save_from_done_count", capture_count, 0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'(i));
         if (i == 15) begin
            check("full_state", state_led, 2);
            check("full_count", capture_count, 16);
         end
      end
      check("overflow_state", state_led, 2);
      check("overflow_count", capture_count, 16);
      push_hdr(16);
      for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("dump16_state", state_led, 3);
      wait_done("dump16", 1'b1);
      check("dump16_count", capture_count, 16);

      // Three bytes, dumped twice, then save/output together
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'hAA);
      step(1'b0, 1'b0, 1'b1, 8'hBB);
      step(1'b0, 1'b0, 1'b1, 8'hCC);
      for (int r = 0; r < 2; r++) begin
         push_hdr(3);
         exp_q.push_back(8'hAA);
         exp_q.push_back(8'hBB);
         exp_q.push_back(8'hCC);
         step(1'b0, 1'b1, 1'b0, 8'h00);
         wait_done($sformatf("dump3_pass%0d", r), 1'b0);
         check($sformatf("dump3_pass%0d_count", r), capture_count, 3);
      end
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check("both_trig_state", state_led, 1);
      check("both_trig_count", capture_count, 0);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("both_trig_no_valid", out_valid, 0);
      check("both_trig_still_capture", state_led, 1);

      // Reset during the second dump byte
      for (int b = 0; b < 4; b++) step(1'b0, 1'b0, 1'b1, 8'h21 + 8'(b));
      push_hdr(4);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'h21 + 8'(b));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("abort_valid_before_rst", out_valid, 1);
      #1;
      sys_rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_state", state_led, 0);
      check("abort_count", capture_count, 0);
      exp_q.delete();
      @(posedge sys_clk);
      #1;
      check("abort_held_valid", out_valid, 0);
      sys_rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("post_rst_trigger_state", state_led, 1);
      step(1'b0, 1'b0, 1'b1, 8'h77);
      check("post_rst_write_count", capture_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
